// File: rtl/mux4_sched_pkg.sv
// rtl/mux4_sched_pkg.sv - shared types and constants for the 4-channel round-robin mux scheduler
package mux4_sched_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int CNT_W  = 3;

  localparam logic [CH_W-1:0] LAST_RESET = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OUTPUT = 2'd2
  } sched_state_e;

  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
    logic [NUM_CH-1:0] v;
    v     = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational round-robin picker over four request lines
module rr_pick4
  import mux4_sched_pkg::*;
(
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   last_i,
  output logic [CH_W-1:0]   winner_o,
  output logic              any_o
);

  logic            found;
  logic [CH_W-1:0] idx;

  // Search starts one past the last winner and wraps; last itself is tried last.
  always_comb begin
    winner_o = last_i;
    found    = 1'b0;
    idx      = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = last_i + CH_W'(i);
      if (!found && req_i[idx]) begin
        winner_o = idx;
        found    = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/mux4_rr_sched.sv
// rtl/mux4_rr_sched.sv - round-robin scheduler driving an external 8-bit 4:1 mux select and capturing its output
module mux4_rr_sched
  import mux4_sched_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  output logic [NUM_CH-1:0] ack,
  output logic              sel1,
  output logic              sel0,
  input  logic [7:0]        mux_f,
  output logic [7:0]        out_data,
  output logic [CH_W-1:0]   out_chan,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  sched_state_e      state_q, state_d;
  logic [CH_W-1:0]   sel_q, sel_d;
  logic [CH_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        data_q, data_d;
  logic [CH_W-1:0]   chan_q, chan_d;
  logic              valid_q, valid_d;
  logic [NUM_CH-1:0] ack_q, ack_d;

  logic [CH_W-1:0]   winner;
  logic              any_req;

  rr_pick4 u_pick (
    .req_i    (req),
    .last_i   (last_q),
    .winner_o (winner),
    .any_o    (any_req)
  );

  // The select only moves when leaving IDLE, so the external mux sees a stable
  // select for the whole settle window and while the byte waits to be taken.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    ack_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          sel_d   = winner;
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          data_d  = mux_f;
          chan_d  = sel_q;
          valid_d = 1'b1;
          ack_d   = ch_onehot(sel_q);
          last_d  = sel_q;
          state_d = ST_OUTPUT;
        end
      end
      ST_OUTPUT: begin
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      last_q  <= LAST_RESET;
      cnt_q   <= '0;
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
    end
  end

  assign sel1      = sel_q[1];
  assign sel0      = sel_q[0];
  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;
  assign ack       = ack_q;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// tb/tb_mux4_rr_sched.sv - directed self-checking bench for mux4_rr_sched
module tb_mux4_rr_sched;

  logic       clk = 1'b0;
  logic       rst_n;

  logic [3:0] req_a, ack_a;
  logic       sel1_a, sel0_a;
  logic [7:0] mux_f_a, out_data_a;
  logic [1:0] out_chan_a;
  logic       out_valid_a, out_ready_a;

  logic [3:0] req_b, ack_b;
  logic       sel1_b, sel0_b;
  logic [7:0] mux_f_b, out_data_b;
  logic [1:0] out_chan_b;
  logic       out_valid_b, out_ready_b;

  int n_checks = 0;
  int n_errors = 0;
  int ack_cnt[4];

  always #5 clk = ~clk;

  mux4_rr_sched #(.SETTLE(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .ack(ack_a), .sel1(sel1_a), .sel0(sel0_a),
    .mux_f(mux_f_a), .out_data(out_data_a), .out_chan(out_chan_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a)
  );

  mux4_rr_sched #(.SETTLE(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .ack(ack_b), .sel1(sel1_b), .sel0(sel0_b),
    .mux_f(mux_f_b), .out_data(out_data_b), .out_chan(out_chan_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full SETTLE=1 transfer on dut a, starting and ending at a negedge in IDLE.
  task automatic xfer_a(input logic [3:0] r, input logic [7:0] d, input logic [1:0] ch,
                        input bit keep);
    logic [3:0] exp_ack;
    exp_ack     = 4'b0001 << ch;
    req_a       = r;
    mux_f_a     = d;
    out_ready_a = 1'b1;
    step();
    check("grant_sel", {sel1_a, sel0_a}, ch);
    check("settle_valid", out_valid_a, 1'b0);
    if (!keep) req_a = 4'b0000;
    step();
    check("cap_valid", out_valid_a, 1'b1);
    check("cap_data", out_data_a, d);
    check("cap_chan", out_chan_a, ch);
    check("cap_ack", ack_a, exp_ack);
    for (int i = 0; i < 4; i++) if (ack_a[i]) ack_cnt[i]++;
    step();
    check("done_valid", out_valid_a, 1'b0);
    check("done_ack", ack_a, 4'b0000);
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = '0; mux_f_a = '0; out_ready_a = 1'b0;
    req_b = '0; mux_f_b = '0; out_ready_b = 1'b0;
    for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
    step();
    step();
    check("rst_sel_a", {sel1_a, sel0_a}, 2'b00);
    check("rst_valid_a", out_valid_a, 1'b0);
    check("rst_data_a", out_data_a, 8'h00);
    check("rst_chan_a", out_chan_a, 2'b00);
    check("rst_ack_a", ack_a, 4'b0000);
    check("rst_valid_b", out_valid_b, 1'b0);
    check("rst_ack_b", ack_b, 4'b0000);
    rst_n = 1'b1;

    // First grant after reset, req dropped during SETTLE, then consumer stall.
    req_a = 4'b0001; mux_f_a = 8'hA4; out_ready_a = 1'b0;
    step();
    check("first_sel", {sel1_a, sel0_a}, 2'b00);
    check("first_valid_pre", out_valid_a, 1'b0);
    check("first_ack_pre", ack_a, 4'b0000);
    req_a = 4'b0000;
    step();
    check("first_valid", out_valid_a, 1'b1);
    check("first_data", out_data_a, 8'hA4);
    check("first_chan", out_chan_a, 2'b00);
    check("first_ack", ack_a, 4'b0001);
    mux_f_a = 8'h55;
    req_a   = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", out_valid_a, 1'b1);
      check("hold_data", out_data_a, 8'hA4);
      check("hold_sel", {sel1_a, sel0_a}, 2'b00);
      check("hold_chan", out_chan_a, 2'b00);
      check("hold_ack", ack_a, 4'b0000);
    end
    out_ready_a = 1'b1;
    step();
    check("release_valid", out_valid_a, 1'b0);

    // Round-robin from last=0 with req=1011.
    xfer_a(4'b1011, 8'h11, 2'd1, 1'b0);
    xfer_a(4'b1011, 8'h22, 2'd3, 1'b0);
    xfer_a(4'b1011, 8'h33, 2'd0, 1'b0);

    // SETTLE=4 instance: capture happens on the 4th edge after sel is driven.
    req_b = 4'b0100; mux_f_b = 8'h10;
    step();
    check("s4_sel", {sel1_b, sel0_b}, 2'b10);
    req_b = 4'b0000; mux_f_b = 8'h11;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("s4_wait_valid", out_valid_b, 1'b0);
      check("s4_wait_sel", {sel1_b, sel0_b}, 2'b10);
      mux_f_b = 8'h11 + 8'(i);
    end
    step();
    check("s4_valid", out_valid_b, 1'b1);
    check("s4_data", out_data_b, 8'h14);
    check("s4_chan", out_chan_b, 2'b10);
    check("s4_ack", ack_b, 4'b0100);
    out_ready_b = 1'b1;
    step();
    check("s4_done_valid", out_valid_b, 1'b0);
    check("s4_done_ack", ack_b, 4'b0000);

    // Reset asserted mid-SETTLE.
    req_a = 4'b0100; mux_f_a = 8'h77;
    step();
    check("pre_rst_sel", {sel1_a, sel0_a}, 2'b10);
    req_a = 4'b0000;
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_sel", {sel1_a, sel0_a}, 2'b00);
    check("async_rst_valid", out_valid_a, 1'b0);
    check("async_rst_data", out_data_a, 8'h00);
    check("async_rst_chan", out_chan_a, 2'b00);
    check("async_rst_ack", ack_a, 4'b0000);
    step();
    check("in_rst_ack", ack_a, 4'b0000);
    check("in_rst_valid", out_valid_a, 1'b0);
    rst_n = 1'b1;

    // Continuous req=1111 after reset: 0,1,2,3 then 0 again.
    for (int i = 0; i < 4; i++) ack_cnt[i] = 0;
    xfer_a(4'b1111, 8'hC0, 2'd0, 1'b1);
    xfer_a(4'b1111, 8'hC1, 2'd1, 1'b1);
    xfer_a(4'b1111, 8'hC2, 2'd2, 1'b1);
    xfer_a(4'b1111, 8'hC3, 2'd3, 1'b1);
    check("fair_ack0", ack_cnt[0], 1);
    check("fair_ack1", ack_cnt[1], 1);
    check("fair_ack2", ack_cnt[2], 1);
    check("fair_ack3", ack_cnt[3], 1);
    xfer_a(4'b1111, 8'hC4, 2'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
